// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory read port, decode handshake and redirect inputs.
interface instruction_fetch_if;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] next_instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        decode_ready;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;

    modport master (
        output imem_rd_en, imem_addr, next_instruction, instr_pc, instr_valid,
        input  imem_rdata, decode_ready, branch_taken, branch_pc, branch_offset,
               jump, jump_target
    );

    modport slave (
        input  imem_rd_en, imem_addr, next_instruction, instr_pc, instr_valid,
        output imem_rdata, decode_ready, branch_taken, branch_pc, branch_offset,
               jump, jump_target
    );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC, 1-cycle-latency imem reads, 2-entry instruction queue, redirects.
// Optional FETCH_PERF_CNT_EN adds fetch_count/flush_count performance counters.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         flush_count
`endif
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned OCC_W = 3;

    typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_REDIRECT} state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } entry_t;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rd_pc_q, rd_pc_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;

    logic             redirect;
    logic             valid;
    logic             push;
    logic             pop;
    logic             issue;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] cnt_v;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  target;
    entry_t           ret_entry;

    // Redirect target; jump keeps the region bits of the delay-slot address
    always_comb begin
        seq_pc = bus.branch_pc + 32'd4;
        if (bus.jump) begin
            target = {seq_pc[31:28], bus.jump_target, 2'b00};
        end else begin
            target = (seq_pc + (bus.branch_offset << 2)) & ~32'd3;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rd_pc_d    = rd_pc_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_v      = count_q;

        redirect   = (state_q != ST_BOOT) && (bus.jump || bus.branch_taken);
        valid      = (count_q != '0) || inflight_q;
        pop        = valid && bus.decode_ready && !redirect;
        push       = inflight_q && !redirect;
        occupancy  = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
        issue      = (state_q != ST_BOOT) && !redirect && (occupancy < OCC_W'(QUEUE_DEPTH));
        inflight_d = issue;
        ret_entry  = '{pc: rd_pc_q, word: bus.imem_rdata};

        case (state_q)
            ST_BOOT:               state_d = ST_FETCH;
            ST_FETCH, ST_REDIRECT: state_d = redirect ? ST_REDIRECT : ST_FETCH;
            default:               state_d = ST_BOOT;
        endcase

        if (issue) begin
            pc_d    = pc_q + 32'd4;
            rd_pc_d = pc_q;
        end

        // Redirect flushes the queue and the word returning this cycle
        if (redirect) begin
            pc_d    = target;
            count_d = '0;
        end else if (count_q == '0) begin
            if (push && !pop) begin
                head_d  = ret_entry;
                count_d = CNT_W'(1);
            end
        end else begin
            if (pop) begin
                head_d = tail_q;
                cnt_v  = count_q - CNT_W'(1);
            end
            if (push) begin
                if (cnt_v == '0) head_d = ret_entry;
                else             tail_d = ret_entry;
                cnt_v = cnt_v + CNT_W'(1);
            end
            count_d = cnt_v;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            rd_pc_q    <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rd_pc_q    <= rd_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // An empty queue passes the returning word straight through to decode
    assign bus.imem_rd_en       = issue;
    assign bus.imem_addr        = issue ? pc_q : '0;
    assign bus.instr_valid      = valid;
    assign bus.next_instruction = ((count_q == '0) && inflight_q) ? bus.imem_rdata : head_q.word;
    assign bus.instr_pc         = ((count_q == '0) && inflight_q) ? rd_pc_q : head_q.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (pop)               fetch_count_q <= fetch_count_q + 32'd1;
            if (redirect && valid) flush_count_q <= flush_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, reset-mid-flight sequence,
// and randomized traffic checked against a program-order reference model.
module tb_instruction_fetch;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    instruction_fetch_if bus();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    instruction_fetch #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count(fetch_count),
        .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h2000_0000 + (a >> 2);
    endfunction

    // Synchronous instruction memory, one cycle read latency
    always @(posedge clk)
        bus.imem_rdata <= bus.imem_rd_en ? memword(bus.imem_addr) : 32'hBAD0_BAD0;

    function automatic logic [31:0] redirect_target(input logic jmp, input logic [31:0] bpc,
                                                    input logic [31:0] boff, input logic [25:0] jt);
        logic [31:0] seq;
        seq = bpc + 32'd4;
        if (jmp) return (seq & 32'hF000_0000) | ({6'b0, jt} << 2);
        return (seq + boff * 32'd4) & 32'hFFFF_FFFC;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic br, input logic jmp,
                         input logic [31:0] bpc, input logic [31:0] boff, input logic [25:0] jt);
        bus.decode_ready  = rdy;
        bus.branch_taken  = br;
        bus.jump          = jmp;
        bus.branch_pc     = bpc;
        bus.branch_offset = boff;
        bus.jump_target   = jt;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        chk({tag, "_rd_en"}, 32'(bus.imem_rd_en), 32'd0);
        chk({tag, "_addr"},  bus.imem_addr, 32'd0);
        chk({tag, "_instr"}, bus.next_instruction, 32'd0);
        chk({tag, "_pc"},    bus.instr_pc, 32'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
        @(negedge clk);
        check_all_zero("reset");
        next_cycle();
        reset = 1'b1;
    endtask

    typedef struct {
        logic        rdy;
        logic        br;
        logic        jmp;
        logic [31:0] bpc;
        logic [31:0] boff;
        logic [25:0] jt;
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t plain(input logic rdy, input logic e_rd, input logic [31:0] e_addr,
                                   input logic e_v, input logic [31:0] e_pc);
        return '{rdy, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0, e_rd, e_addr, e_v, e_pc};
    endfunction

    function automatic vec_t redir(input logic br, input logic jmp, input logic [31:0] bpc,
                                   input logic [31:0] boff, input logic [25:0] jt,
                                   input logic [31:0] e_pc);
        return '{1'b1, br, jmp, bpc, boff, jt, 1'b0, 32'd0, 1'b1, e_pc};
    endfunction

    vec_t vec [24];

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_issue;
        logic [31:0] exp_pop;
        logic [31:0] bpc;
        logic [31:0] boff;
        logic [31:0] r;
        logic [25:0] jt;
        logic        rdy;
        logic        br;
        logic        jmp;
        logic        do_redir;
        int          outstanding;
        int          pops;

        // Cycle 1 is the boot cycle after reset release
        vec[0]  = plain(1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
        vec[1]  = plain(1'b1, 1'b1, 32'h0,         1'b0, 32'h0);
        vec[2]  = plain(1'b1, 1'b1, 32'h4,         1'b1, 32'h0);
        vec[3]  = plain(1'b1, 1'b1, 32'h8,         1'b1, 32'h4);
        vec[4]  = plain(1'b1, 1'b1, 32'hC,         1'b1, 32'h8);
        vec[5]  = plain(1'b1, 1'b1, 32'h10,        1'b1, 32'hC);
        vec[6]  = redir(1'b1, 1'b0, 32'h10, 32'hFFFF_FFFE, 26'h0, 32'h10);
        vec[7]  = plain(1'b1, 1'b1, 32'hC,         1'b0, 32'h0);
        vec[8]  = plain(1'b1, 1'b1, 32'h10,        1'b1, 32'hC);
        vec[9]  = redir(1'b1, 1'b1, 32'h4000_0000, 32'h0000_0040, 26'h0000100, 32'h10);
        vec[10] = plain(1'b1, 1'b1, 32'h4000_0400, 1'b0, 32'h0);
        vec[11] = plain(1'b1, 1'b1, 32'h4000_0404, 1'b1, 32'h4000_0400);
        vec[12] = plain(1'b0, 1'b1, 32'h4000_0408, 1'b1, 32'h4000_0404);
        vec[13] = plain(1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0404);
        vec[14] = plain(1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0404);
        vec[15] = plain(1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0404);
        vec[16] = plain(1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0404);
        vec[17] = plain(1'b1, 1'b1, 32'h4000_040C, 1'b1, 32'h4000_0404);
        vec[18] = plain(1'b1, 1'b1, 32'h4000_0410, 1'b1, 32'h4000_0408);
        vec[19] = plain(1'b1, 1'b1, 32'h4000_0414, 1'b1, 32'h4000_040C);
        vec[20] = redir(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_0002, 26'h0, 32'h4000_0410);
        vec[21] = plain(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        vec[22] = plain(1'b1, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC);
        vec[23] = plain(1'b1, 1'b1, 32'h4,         1'b1, 32'h0);

        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
        #3;
        apply_reset();

        for (int i = 0; i < 24; i++) begin
            drive(vec[i].rdy, vec[i].br, vec[i].jmp, vec[i].bpc, vec[i].boff, vec[i].jt);
            @(negedge clk);
            chk($sformatf("vec%0d_rd_en", i), 32'(bus.imem_rd_en), 32'(vec[i].e_rd));
            if (vec[i].e_rd) chk($sformatf("vec%0d_addr", i), bus.imem_addr, vec[i].e_addr);
            chk($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(vec[i].e_v));
            if (vec[i].e_v) begin
                chk($sformatf("vec%0d_pc", i), bus.instr_pc, vec[i].e_pc);
                chk($sformatf("vec%0d_instr", i), bus.next_instruction, memword(vec[i].e_pc));
            end
            next_cycle();
        end

        // Reset while one word is queued and the read of the next is returning
        apply_reset();
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("mid_c2_rd_en", 32'(bus.imem_rd_en), 32'd1);
        chk("mid_c2_addr", bus.imem_addr, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("mid_c3_valid", 32'(bus.instr_valid), 32'd1);
        chk("mid_c3_pc", bus.instr_pc, 32'h0);
        next_cycle();
        reset = 1'b0;
        #2;
        check_all_zero("midrst");
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
        @(negedge clk);
        chk("boot_valid", 32'(bus.instr_valid), 32'd0);
        chk("boot_rd_en", 32'(bus.imem_rd_en), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("restart_rd_en", 32'(bus.imem_rd_en), 32'd1);
        chk("restart_addr", bus.imem_addr, 32'h0);
        chk("restart_valid_low", 32'(bus.instr_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("restart_valid", 32'(bus.instr_valid), 32'd1);
        chk("restart_pc", bus.instr_pc, 32'h0);
        chk("restart_instr", bus.next_instruction, 32'h2000_0000);
        next_cycle();

        // Randomized traffic against a program-order model
        apply_reset();
        exp_issue   = 32'h0;
        exp_pop     = 32'h0;
        outstanding = 0;
        pops        = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy      = ($urandom_range(0, 3) != 0);
            do_redir = (cyc > 0) && ($urandom_range(0, 15) == 0);
            jmp      = do_redir && ($urandom_range(0, 1) == 1);
            br       = do_redir && (!jmp || ($urandom_range(0, 1) == 1));
            bpc      = $urandom() & 32'hFFFF_FFFC;
            r        = $urandom();
            boff     = {{16{r[15]}}, r[15:0]};
            jt       = 26'($urandom());
            drive(rdy, br, jmp, bpc, boff, jt);
            @(negedge clk);
            if (do_redir) begin
                chk("rand_redirect_no_issue", 32'(bus.imem_rd_en), 32'd0);
                exp_issue   = redirect_target(jmp, bpc, boff, jt);
                exp_pop     = exp_issue;
                outstanding = 0;
            end else begin
                if (bus.imem_rd_en) begin
                    chk("rand_issue_addr", bus.imem_addr, exp_issue);
                    exp_issue   = exp_issue + 32'd4;
                    outstanding = outstanding + 1;
                end
                if (bus.instr_valid && rdy) begin
                    chk("rand_pop_pc", bus.instr_pc, exp_pop);
                    chk("rand_pop_instr", bus.next_instruction, memword(exp_pop));
                    exp_pop     = exp_pop + 32'd4;
                    outstanding = outstanding - 1;
                    pops        = pops + 1;
                end
                chk("rand_occupancy_ok", 32'(outstanding >= 0 && outstanding <= 2), 32'd1);
            end
            next_cycle();
        end
        chk("rand_throughput", 32'(pops > 1000), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
